alu_pipe: RTL and testbench

- Parametrised, registered successor to the combinational ALU.
- Adds a valid/ready handshake on input and output, a registered result stage, and an iterative multi-cycle multiplier FSM.
- Adds zero, signed-overflow and illegal-opcode flags.
- Sits between decode and writeback/LSU; A carries the effective address for memory operations.

---
 rtl/alu_pipe.sv | 197 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered ALU stage between decode and writeback/LSU.
// It has valid/ready handshakes on input and output and an iterative shift-add multiplier.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] A,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(6'b000011);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6'b001001);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(6'b001010);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b001100);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b001101);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(6'b010000);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             is_sub;
    logic             use_imm;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_b_eff;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] alu_rd;
    logic [WIDTH-1:0] alu_a;
    logic             alu_ovf;
    logic             alu_err;
    logic             is_mul;
    logic [WIDTH-1:0] mul_step;

    assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Overflow uses the negated subtrahend as the effective second operand.
    assign is_sub    = (op == OP_SUB) || (op == OP_SUBI);
    assign use_imm   = (op == OP_ADDI) || (op == OP_SUBI);
    assign add_b     = use_imm ? imm : rt;
    assign add_b_eff = is_sub ? (~add_b + WIDTH'(1)) : add_b;
    assign add_sum   = rs + add_b_eff;
    assign add_ovf   = (rs[WIDTH-1] == add_b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != rs[WIDTH-1]);
    assign ea        = rs + imm;

    always_comb begin
        alu_rd  = '0;
        alu_a   = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        is_mul  = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
                alu_rd  = add_sum;
                alu_ovf = add_ovf;
            end
            OP_AND: alu_rd = rs & rt;
            OP_OR:  alu_rd = rs | rt;
            OP_XOR: alu_rd = rs ^ rt;
            OP_LW:  alu_a  = ea;
            OP_SW: begin
                alu_a  = ea;
                alu_rd = rt;
            end
            OP_MUL:  is_mul  = 1'b1;
            default: alu_err = 1'b1;
        endcase
    end

    assign mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        a_d         = a_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (is_mul) begin
                        mcand_d     = rs;
                        mplier_d    = rt;
                        acc_d       = '0;
                        cnt_d       = CW'(WIDTH);
                        out_valid_d = 1'b0;
                        state_d     = MUL_BUSY;
                    end else begin
                        rd_d        = alu_rd;
                        a_d         = alu_a;
                        zero_d      = (alu_rd == '0);
                        ovf_d       = alu_ovf;
                        err_d       = alu_err;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                acc_d    = mul_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // The final iteration's sum goes straight to rd on the same edge.
                if (cnt_q == CW'(1)) begin
                    rd_d        = mul_step;
                    a_d         = '0;
                    zero_d      = (mul_step == '0);
                    ovf_d       = 1'b0;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            a_q         <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            a_q         <= a_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign A         = a_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe.
// Each task drives one scenario and checks the outputs against hand-computed values.
module tb_alu_pipe;

    localparam int W = 32;

    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] SUB  = 6'b000001;
    localparam logic [5:0] SUBI = 6'b000011;
    localparam logic [5:0] AND_ = 6'b001000;
    localparam logic [5:0] OR_  = 6'b001001;
    localparam logic [5:0] XOR_ = 6'b001010;
    localparam logic [5:0] LW   = 6'b001100;
    localparam logic [5:0] SW   = 6'b001101;
    localparam logic [5:0] MUL  = 6'b010000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   op;
    logic [W-1:0] rs, rt, imm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] rd, A;
    logic         zero, ovf, err;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(W), .OPW(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs(rs), .rt(rt), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .A(A), .zero(zero), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] i);
        in_valid = 1'b1;
        op = o;
        rs = a;
        rt = b;
        imm = i;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL reset_rd: got %h expected 0", rd); end
        checks++; if ({A, zero, ovf, err} !== '0) begin errors++; $display("FAIL reset_flags: got A=%h z=%b o=%b e=%b expected all 0", A, zero, ovf, err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during_rst: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(ADD, 32'h0000000A, 32'h00000005, 32'h0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
        checks++; if (rd !== 32'h0000000F) begin errors++; $display("FAIL add_rd: got %h expected 0000000f", rd); end
        checks++; if ({zero, ovf, err} !== 3'b000) begin errors++; $display("FAIL add_flags: got %b expected 000", {zero, ovf, err}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(SUBI, 32'h0A, 32'h0, 32'hFFFFFFF5);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || rd !== 32'h15 || ovf !== 1'b0) begin errors++; $display("FAIL b2b_subi: got v=%b rd=%h ovf=%b expected v=1 rd=00000015 ovf=0", out_valid, rd, ovf); end
        drive(XOR_, 32'h0A, 32'hF0, 32'h0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || rd !== 32'hFA || A !== '0) begin errors++; $display("FAIL b2b_xor: got v=%b rd=%h A=%h expected v=1 rd=000000fa A=0", out_valid, rd, A); end
        drive(LW, 32'h100, 32'h0, 32'h8);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || rd !== '0 || A !== 32'h108 || zero !== 1'b1) begin errors++; $display("FAIL b2b_lw: got v=%b rd=%h A=%h z=%b expected v=1 rd=0 A=00000108 z=1", out_valid, rd, A, zero); end
        tick();
    endtask

    task automatic test_logic_mem();
        out_ready = 1'b1;
        drive(AND_, 32'h0000F0F0, 32'h0000FF00, 32'h0);
        tick();
        checks++; if (rd !== 32'h0000F000) begin errors++; $display("FAIL and_rd: got %h expected 0000f000", rd); end
        drive(OR_, 32'h0000F0F0, 32'h0000FF00, 32'h0);
        tick();
        checks++; if (rd !== 32'h0000FFF0) begin errors++; $display("FAIL or_rd: got %h expected 0000fff0", rd); end
        drive(SW, 32'h200, 32'hDEADBEEF, 32'hFFFFFFFC);
        tick();
        in_valid = 1'b0;
        checks++; if (rd !== 32'hDEADBEEF || A !== 32'h1FC || err !== 1'b0) begin errors++; $display("FAIL sw: got rd=%h A=%h err=%b expected rd=deadbeef A=000001fc err=0", rd, A, err); end
        tick();
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        drive(ADD, 32'h7FFFFFFF, 32'h1, 32'h0);
        tick();
        checks++; if (rd !== 32'h80000000 || ovf !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL add_ovf: got rd=%h ovf=%b z=%b expected rd=80000000 ovf=1 z=0", rd, ovf, zero); end
        drive(SUB, 32'h5, 32'h5, 32'h0);
        tick();
        in_valid = 1'b0;
        checks++; if (rd !== '0 || zero !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL sub_zero: got rd=%h z=%b ovf=%b expected rd=0 z=1 ovf=0", rd, zero, ovf); end
        tick();
    endtask

    task automatic test_mul();
        int k;
        logic leak;
        out_ready = 1'b1;
        drive(MUL, 32'h7, 32'h6, 32'h0);
        tick();
        in_valid = 1'b0;
        rs = 32'h12345678;
        rt = 32'h9ABCDEF0;
        k = 0;
        leak = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready !== 1'b0) leak = 1'b1;
            tick();
            k++;
            if (out_valid === 1'b1) break;
        end
        checks++; if (leak !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy: got leak=%b expected 0", leak); end
        checks++; if (k !== 32) begin errors++; $display("FAIL mul_latency: got %0d expected 32", k); end
        checks++; if (out_valid !== 1'b1 || rd !== 32'h2A || {zero, ovf, err} !== 3'b000) begin errors++; $display("FAIL mul_rd: got v=%b rd=%h flags=%b expected v=1 rd=0000002a flags=000", out_valid, rd, {zero, ovf, err}); end
        drive(MUL, 32'hFFFFFFFF, 32'h2, 32'h0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul2_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul2_valid_drop: got %b expected 0", out_valid); end
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            k++;
            if (out_valid === 1'b1) break;
        end
        checks++; if (k !== 32 || rd !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul2: got lat=%0d rd=%h expected lat=32 rd=fffffffe", k, rd); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        logic bad;
        out_ready = 1'b1;
        drive(XOR_, 32'h12345678, 32'hFFFF0000, 32'h0);
        tick();
        held = rd;
        checks++; if (rd !== 32'hEDCB5678) begin errors++; $display("FAIL bp_xor: got %h expected edcb5678", rd); end
        out_ready = 1'b0;
        drive(ADD, 32'h1, 32'h1, 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (in_ready !== 1'b0) bad = 1'b1;
            tick();
            if (out_valid !== 1'b1 || rd !== held || zero !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bp_hold: got bad=%b rd=%h expected bad=0 rd=%h", bad, rd, held); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || rd !== 32'h2) begin errors++; $display("FAIL bp_swap: got v=%b rd=%h expected v=1 rd=00000002", out_valid, rd); end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        logic seen;
        out_ready = 1'b1;
        drive(MUL, 32'h3, 32'h3, 32'h0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mul: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mul_ghost: got seen=%b expected 0", seen); end
        drive(6'b111111, 32'h55, 32'h66, 32'h77);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || err !== 1'b1 || rd !== '0 || zero !== 1'b1 || A !== '0 || ovf !== 1'b0) begin errors++; $display("FAIL illegal: got v=%b err=%b rd=%h z=%b A=%h ovf=%b expected v=1 err=1 rd=0 z=1 A=0 ovf=0", out_valid, err, rd, zero, A, ovf); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        rs = '0;
        rt = '0;
        imm = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_logic_mem();
        test_overflow();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
